// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer computing base^exp mod Q
// through a single shared modular multiplier with MUL_LAT cycles of latency.
module mod_exp_ctrl #(
    parameter int             W       = 32,
    parameter int             EW      = 32,
    parameter logic [W-1:0]   Q       = 32'd4294955009,
    parameter int             MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [W-1:0]  mul_a,
    output logic [W-1:0]  mul_b,
    output logic          mul_start,
    input  logic [W-1:0]  mul_p
);

    localparam int             CW      = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MUL_LAT);

    typedef enum logic [1:0] {IDLE, MUL, SQR, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   b_q, b_d;
    logic [EW-1:0]  e_q, e_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic           last;
    logic [W-1:0]   base_red;
    logic [EW-1:0]  e_shr;

    // Q > 2^(W-1), so one conditional subtract fully reduces any W-bit base.
    assign base_red = ({1'b0, base} >= {1'b0, Q}) ? (base - Q) : base;
    assign last     = (cnt_q == CNT_MAX);
    assign e_shr    = e_q >> 1;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        b_d      = b_q;
        e_d      = e_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d   = base_red;
                    e_d   = exp;
                    r_d   = W'(1);
                    cnt_d = '0;
                    if (exp == '0)  state_d = DONE;
                    else if (exp[0]) state_d = MUL;
                    else             state_d = SQR;
                end
            end
            MUL: begin
                if (last) begin
                    cnt_d   = '0;
                    r_d     = mul_p;
                    state_d = (e_shr == '0) ? DONE : SQR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SQR: begin
                // SQR is only reached while e>>1 != 0, so the final square is skipped.
                if (last) begin
                    cnt_d   = '0;
                    b_d     = mul_p;
                    e_d     = e_shr;
                    state_d = e_shr[0] ? MUL : SQR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) result_d = r_d;
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r_q      <= '0;
            b_q      <= '0;
            e_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            b_q      <= b_d;
            e_q      <= e_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign mul_a     = (state_q == MUL) ? r_q : (state_q == SQR) ? b_q : '0;
    assign mul_b     = (state_q == MUL || state_q == SQR) ? b_q : '0;
    assign mul_start = (state_q == MUL || state_q == SQR) && (cnt_q == '0);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: three instances (MUL_LAT 0/1/3), each driving a
// delayed modular-multiplier model, checked against a plain pow-mod model.
module tb_mod_exp_ctrl;

    localparam int           W  = 32;
    localparam int           EW = 32;
    localparam logic [W-1:0] Q  = 32'd4294955009;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    start_v;
    logic [W-1:0]  base_i;
    logic [EW-1:0] exp_i;
    logic [2:0]    busy_v, done_v, mst_v;
    logic [W-1:0]  res_v [3];
    logic [W-1:0]  a_v   [3];
    logic [W-1:0]  b_v   [3];
    logic [W-1:0]  p_v   [3];
    logic [W-1:0]  prod  [3];
    logic [W-1:0]  l1;
    logic [W-1:0]  l3    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.W(W), .EW(EW), .Q(Q), .MUL_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .base(base_i), .exp(exp_i),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .mul_a(a_v[0]),
        .mul_b(b_v[0]), .mul_start(mst_v[0]), .mul_p(p_v[0]));
    mod_exp_ctrl #(.W(W), .EW(EW), .Q(Q), .MUL_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .base(base_i), .exp(exp_i),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .mul_a(a_v[1]),
        .mul_b(b_v[1]), .mul_start(mst_v[1]), .mul_p(p_v[1]));
    mod_exp_ctrl #(.W(W), .EW(EW), .Q(Q), .MUL_LAT(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .base(base_i), .exp(exp_i),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .mul_a(a_v[2]),
        .mul_b(b_v[2]), .mul_start(mst_v[2]), .mul_p(p_v[2]));

    // Multiplier model: product appears exactly MUL_LAT edges after the operands.
    always_comb begin
        for (int i = 0; i < 3; i++)
            prod[i] = W'((64'(a_v[i]) * 64'(b_v[i])) % 64'(Q));
        p_v[0] = prod[0];
        p_v[1] = l1;
        p_v[2] = l3[2];
    end

    always @(posedge clk) begin
        l1    <= prod[1];
        l3[0] <= prod[2];
        l3[1] <= l3[0];
        l3[2] <= l3[1];
    end

    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] bs, input logic [EW-1:0] ex);
        longint unsigned r;
        longint unsigned bb;
        r  = 1;
        bb = 64'(bs) % 64'(Q);
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % 64'(Q);
            if (ex[i]) r = (r * bb) % 64'(Q);
        end
        return W'(r);
    endfunction

    function automatic int ref_n(input logic [EW-1:0] ex);
        int m;
        m = 0;
        if (ex == '0) return 0;
        for (int i = 0; i < EW; i++) if (ex[i]) m = i;
        return $countones(ex) + m;
    endfunction

    function automatic int k_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
    endfunction

    // Starts one operation on instance sel; cycle 0 is the start-sampling cycle.
    // Optionally re-asserts start (9, 1) in cycle inj to probe the ignore rule.
    task automatic run_op(input int sel, input logic [W-1:0] bs, input logic [EW-1:0] ex,
                          input int inj, output int dcyc, output logic [W-1:0] res,
                          output int nst, output bit bsy_ok, output logic [31:0] mmap,
                          output logic [W-1:0] a1, output logic [W-1:0] b1,
                          output logic [W-1:0] pre_res, output logic pre_busy);
        bit got;
        @(negedge clk);
        pre_res  = res_v[sel];
        pre_busy = busy_v[sel];
        base_i = bs;
        exp_i  = ex;
        start_v = 3'b000;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        base_i  = $urandom;
        exp_i   = $urandom;
        dcyc = -1; nst = 0; bsy_ok = 1'b1; res = '0; got = 1'b0;
        mmap = '0; a1 = '0; b1 = '0;
        for (int k = 1; k <= 600 && !got; k++) begin
            @(negedge clk);
            if (!busy_v[sel]) bsy_ok = 1'b0;
            if (mst_v[sel]) nst++;
            if (k < 32) mmap[k] = mst_v[sel];
            if (k == 1) begin a1 = a_v[sel]; b1 = b_v[sel]; end
            if (done_v[sel]) begin
                got = 1'b1; dcyc = k; res = res_v[sel];
            end else if (k == inj) begin
                base_i = 9; exp_i = 1; start_v[sel] = 1'b1;
                @(posedge clk);
                #1 start_v = 3'b000;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_v[i], done_v[i], mst_v[i], res_v[i], a_v[i], b_v[i]} !== '0) begin
                errors++;
                $display("FAIL reset inst%0d busy=%b done=%b mst=%b res=%0d a=%0d b=%0d want all 0",
                         i, busy_v[i], done_v[i], mst_v[i], res_v[i], a_v[i], b_v[i]);
            end
        end
    endtask

    task automatic test_exp_zero();
        int dc, ns; logic [W-1:0] rs, a1, b1, pr; bit bo; logic [31:0] mm; logic pb;
        run_op(1, 7, 0, -1, dc, rs, ns, bo, mm, a1, b1, pr, pb);
        checks++; if (dc != 1) begin errors++; $display("FAIL exp0_cycle got %0d want 1", dc); end
        checks++; if (rs !== 1) begin errors++; $display("FAIL exp0_result got %0d want 1", rs); end
        checks++; if (ns != 0) begin errors++; $display("FAIL exp0_mulstart got %0d want 0", ns); end
    endtask

    task automatic test_normal();
        int dc, ns; logic [W-1:0] rs, a1, b1, pr; bit bo; logic [31:0] mm; logic pb;
        run_op(1, 3, 13, -1, dc, rs, ns, bo, mm, a1, b1, pr, pb);
        checks++; if (dc != 13) begin errors++; $display("FAIL normal_cycle got %0d want 13", dc); end
        checks++; if (rs !== 32'd1594323) begin errors++; $display("FAIL normal_result got %0d want 1594323", rs); end
        checks++; if (mm !== 32'h0000_0AAA) begin errors++; $display("FAIL normal_mulstart_map got %h want 00000aaa", mm); end
        checks++; if (!bo) begin errors++; $display("FAIL normal_busy got low want high"); end
    endtask

    task automatic test_base_reduce();
        int dc, ns; logic [W-1:0] rs, a1, b1, pr; bit bo; logic [31:0] mm; logic pb;
        run_op(1, Q + 32'd5, 2, -1, dc, rs, ns, bo, mm, a1, b1, pr, pb);
        checks++; if (a1 !== 5 || b1 !== 5) begin errors++; $display("FAIL reduce_operands got a=%0d b=%0d want 5 5", a1, b1); end
        checks++; if (dc != 5) begin errors++; $display("FAIL reduce_cycle got %0d want 5", dc); end
        checks++; if (rs !== 25) begin errors++; $display("FAIL reduce_result got %0d want 25", rs); end
    endtask

    task automatic test_back_to_back();
        int dc, ns; logic [W-1:0] rs, a1, b1, pr; bit bo; logic [31:0] mm; logic pb;
        run_op(1, 2, 10, 3, dc, rs, ns, bo, mm, a1, b1, pr, pb);
        checks++; if (dc != 11) begin errors++; $display("FAIL busy_start_cycle got %0d want 11", dc); end
        checks++; if (rs !== 1024) begin errors++; $display("FAIL busy_start_result got %0d want 1024", rs); end
        run_op(1, 9, 1, -1, dc, rs, ns, bo, mm, a1, b1, pr, pb);
        checks++; if (pr !== 1024 || pb !== 1'b0) begin errors++; $display("FAIL b2b_idle got res=%0d busy=%b want 1024 0", pr, pb); end
        checks++; if (dc != 3) begin errors++; $display("FAIL b2b_cycle got %0d want 3 (abs 15)", dc); end
        checks++; if (rs !== 9) begin errors++; $display("FAIL b2b_result got %0d want 9", rs); end
    endtask

    task automatic test_reset_mid();
        int dc, ns; logic [W-1:0] rs, a1, b1, pr; bit bo; logic [31:0] mm; logic pb;
        bit saw_done;
        @(negedge clk);
        base_i = 3; exp_i = 13; start_v = 3'b010;
        @(posedge clk);
        #1 start_v = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_v[1] !== 1'b0 || res_v[1] !== '0 || done_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b res=%0d done=%b want 0 0 0", busy_v[1], res_v[1], done_v[1]);
        end
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done_v[1]) saw_done = 1'b1; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done_v[1]) saw_done = 1'b1; end
        checks++; if (saw_done) begin errors++; $display("FAIL reset_mid_nodone got done pulse want none"); end
        run_op(1, 3, 13, -1, dc, rs, ns, bo, mm, a1, b1, pr, pb);
        checks++; if (dc != 13 || rs !== 32'd1594323) begin errors++; $display("FAIL reset_rerun got cyc=%0d res=%0d want 13 1594323", dc, rs); end
    endtask

    task automatic test_random();
        int dc, ns, sel, n_exp, c_exp; logic [W-1:0] rs, a1, b1, pr, bs, r_exp; bit bo;
        logic [31:0] mm; logic pb; logic [EW-1:0] ex;
        for (int n = 0; n < 500; n++) begin
            sel = n % 3;
            bs  = $urandom;
            if (n % 7 == 0) bs = Q + W'($urandom_range(0, 12286));
            if (n % 50 < 3)       ex = '1;
            else if (n % 50 == 3) ex = '0;
            else                  ex = $urandom >> $urandom_range(0, 31);
            r_exp = ref_pow(bs, ex);
            n_exp = ref_n(ex);
            c_exp = 1 + n_exp * k_of(sel);
            run_op(sel, bs, ex, -1, dc, rs, ns, bo, mm, a1, b1, pr, pb);
            checks++;
            if (rs !== r_exp) begin errors++; $display("FAIL rand_result inst%0d base=%0d exp=%h got %0d want %0d", sel, bs, ex, rs, r_exp); end
            checks++;
            if (dc != c_exp) begin errors++; $display("FAIL rand_cycle inst%0d exp=%h got %0d want %0d", sel, ex, dc, c_exp); end
            checks++;
            if (ns != n_exp) begin errors++; $display("FAIL rand_mulstart inst%0d exp=%h got %0d want %0d", sel, ex, ns, n_exp); end
            checks++;
            if (!bo) begin errors++; $display("FAIL rand_busy inst%0d exp=%h got low want high", sel, ex); end
        end
    endtask

    initial begin
        start_v = 3'b000;
        base_i  = '0;
        exp_i   = '0;
        repeat (2) @(posedge clk);
        #1 test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_exp_zero();
        test_normal();
        test_base_reduce();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Sequencer that computes base^exp mod Q by driving one shared modular multiplier, the semi-Karatsuba reducing multiplier, with right-to-left square-and-multiply. It sits between the host-side start/done handshake and the multiplier instance. Exactly one multiplication is in flight at a time. The multiplier is external and returns a fully reduced product in [0, Q).

## Interface
- W, 32: operand/result width (2*v of the multiplier)
- EW, 32: exponent width
- Q, 32'd4294955009: modulus; must satisfy 2^(W-1) < Q < 2^W
- MUL_LAT, 1: multiplier latency in cycles (0 means combinational)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- base  in  W  base operand; any value in [0, 2^W)
- exp  in  EW  exponent
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result is valid in that cycle
- result  out  W  registered; held from done until the next accepted start
- mul_a, mul_b  out  W  multiplier operands
- mul_start  out  1  high in the first cycle of each multiplication
- mul_p  in  W  multiplier product, (mul_a*mul_b) mod Q

## Operation
- Registers:
  - r: accumulator, W bits
  - b: running square, W bits
  - e: remaining exponent, EW bits
  - cnt: latency counter, ceil(log2(MUL_LAT+1)) bits, minimum 1
  - state: IDLE, MUL, SQR, DONE
- Reset values: state = IDLE, r = b = e = cnt = 0, result = 0, done = 0, busy = 0.
- Operand muxing, from state:
  - MUL: mul_a = r, mul_b = b
  - SQR: mul_a = mul_b = b
  - IDLE/DONE: both 0
  - Operands are constant for the whole multiplication.
- IDLE with start = 1:
  - Load b = (base >= Q) ? base - Q : base. A single subtract is sufficient because Q > 2^(W-1).
  - Load e = exp, r = 1, cnt = 0.
  - Next state: DONE if exp == 0, else MUL if exp[0] == 1, else SQR.
- Each MUL/SQR visit lasts exactly K = MUL_LAT+1 cycles.
  - cnt counts 0..MUL_LAT.
  - mul_start = 1 when cnt == 0.
  - mul_p is captured at the edge ending the cycle with cnt == MUL_LAT; cnt then returns to 0.
- MUL completion: r <= mul_p. Next state is DONE if (e >> 1) == 0, else SQR.
- SQR completion: b <= mul_p, e <= e >> 1. Next state is MUL if e[1] == 1, else SQR.
  - SQR is only entered while (e >> 1) != 0, so the final square is never issued.
- DONE (one cycle): done = 1, result <= r is already visible that cycle; the next state is IDLE.
  - Implement result as a register loaded on DONE entry, so it equals r in the done cycle.
- start during MUL/SQR/DONE is ignored; there is no queuing.
- Width rules:
  - All arithmetic is W bits.
  - The base subtract uses a W+1-bit compare.
  - mul_p is trusted to be < Q.

## Timing
- The cycle in which start is sampled high in IDLE is cycle 0.
- N = popcount(exp) + msb_index(exp); N = 0 when exp == 0.
- done is high in cycle 1 + N*K. busy is high in cycles 1 .. 1+N*K inclusive.
- Back-to-back operation: start may be asserted in the cycle after done (IDLE) and is accepted.
- Reset asserted mid-operation:
  - Immediately clear state to IDLE and all registers to their reset values.
  - No done pulse is produced.
  - result reads 0 after reset.
- MUL_LAT = 0: K = 1. mul_p is sampled in the issue cycle, and mul_start is high every busy MUL/SQR cycle.
- Worst case: exp = 2^EW - 1 gives N = 2*EW - 1.

## Test plan
- **exp = 0:** base = 7, exp = 0, MUL_LAT = 1 → done at cycle 1, result = 1, no mul_start pulse.
- **Normal square-and-multiply:** base = 3, exp = 13, MUL_LAT = 1 → N = 6; mul_start pulses in cycles 1,3,5,7,9,11; done at cycle 13; result = 1594323.
- **Base reduction:** base = 4294955014 (Q+5), exp = 2 → first operands are b = 5; N = 2; done at cycle 5 with K = 2; result = 25.
- **Start while busy:** base = 2, exp = 10; second start with base = 9, exp = 1 at cycle 3 → ignored; done at cycle 1+5*2 = 11 with result = 1024; a start in cycle 12 with (9, 1) is accepted, giving done at cycle 15 and result = 9.
- **Reset mid-operation:** rst_n low at cycle 4 of (3, 13) → busy = 0 and result = 0 immediately; no done; a new run of (3, 13) completes normally.
- **Random reference check:** 500 random base/exp pairs with MUL_LAT ∈ {0, 1, 3}, including exp = 2^32-1, against a reference pow-mod → result matches and the done cycle equals 1 + N*K every time.
